// File: rtl/phase_unwrap.sv
// Phase unwrapper: rebuilds a continuous phase sequence per frame from wrapped
// [-pi, pi) samples. Three-stage pipeline (diff, offset update, add/saturate),
// one sample per cycle, framed by frame_start/frame_len.
`timescale 1ns / 1ps

module phase_unwrap #(
    parameter int unsigned IN_W  = 48,
    parameter int unsigned OUT_W = 56,
    parameter int unsigned LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             frame_start,
    input  logic [IN_W-1:0]  angle_in,
    input  logic             angle_in_valid,
    output logic [OUT_W-1:0] unwrap_out,
    output logic             unwrap_out_valid,
    output logic             unwrap_out_last,
    output logic             overflow,
    output logic             busy
);

    // pi and 2*pi with 45 fraction bits, zero-extended so they stay positive
    localparam logic signed [IN_W:0]  Pi    = (IN_W+1)'(48'h6487ED5110B4);
    localparam logic signed [OUT_W:0] TwoPi = (OUT_W+1)'(48'hC90FDAA22168);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                  state;
    logic [LEN_W-1:0]        count;
    logic                    first_pend;

    logic                    start_acc;
    logic                    accept;
    logic [LEN_W-1:0]        cnt_eff;
    logic                    is_last;
    logic                    is_first;
    logic signed [IN_W:0]    diff;

    logic [IN_W-1:0]         prev_x;
    logic                    s1_valid;
    logic [IN_W-1:0]         s1_x;
    logic signed [IN_W:0]    s1_d;
    logic                    s1_first;
    logic                    s1_last;

    logic signed [OUT_W:0]   offset;
    logic signed [OUT_W:0]   offset_step;
    logic signed [OUT_W:0]   next_offset;
    logic                    s2_valid;
    logic [IN_W-1:0]         s2_x;
    logic                    s2_last;

    logic signed [OUT_W:0]   x_ext;
    logic signed [OUT_W:0]   sum;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        sat_val;

    // Frame control decode; a zero-length frame_start is ignored in any state.
    // A sample coincident with an accepted frame_start belongs to the new frame.
    always_comb begin
        start_acc = frame_start && (frame_len != '0);
        accept    = angle_in_valid && ((state == StRun) || start_acc);
        cnt_eff   = start_acc ? frame_len : count;
        is_last   = (cnt_eff == LEN_W'(1));
        is_first  = start_acc || first_pend;
        diff      = $signed({angle_in[IN_W-1], angle_in}) - $signed({prev_x[IN_W-1], prev_x});
    end

    // IDLE/RUN frame FSM with sample counter, first-sample flag and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            count      <= '0;
            first_pend <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            count      <= cnt_eff - LEN_W'(1);
            first_pend <= 1'b0;
            if (is_last) begin
                state <= StIdle;
                busy  <= 1'b0;
            end else begin
                state <= StRun;
                busy  <= 1'b1;
            end
        end else if (start_acc) begin
            count      <= frame_len;
            first_pend <= 1'b1;
            state      <= StRun;
            busy       <= 1'b1;
        end
    end

    // S1: register sample, tags and the difference to the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_d     <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            prev_x   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_x     <= angle_in;
                s1_d     <= diff;
                s1_first <= is_first;
                s1_last  <= is_last;
                prev_x   <= angle_in;
            end
        end
    end

    // S2 next offset: a jump of exactly +/-pi is left uncorrected
    always_comb begin
        offset_step = offset;
        if (s1_d > Pi) begin
            offset_step = offset - TwoPi;
        end else if (s1_d < -Pi) begin
            offset_step = offset + TwoPi;
        end
        next_offset = s1_first ? '0 : offset_step;
    end

    // S2: update the running offset in sample order, so older frames finish cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_last  <= 1'b0;
            offset   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x    <= s1_x;
                s2_last <= s1_last;
                offset  <= next_offset;
            end
        end
    end

    // S3 add at OUT_W+1 bits and clamp to the OUT_W signed range
    always_comb begin
        x_ext  = $signed({{(OUT_W+1-IN_W){s2_x[IN_W-1]}}, s2_x});
        sum    = x_ext + offset;
        sat_hi = !sum[OUT_W] && sum[OUT_W-1];
        sat_lo = sum[OUT_W] && !sum[OUT_W-1];
        if (sat_hi) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_val = sum[OUT_W-1:0];
        end
    end

    // S3: registered outputs and sticky per-frame overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            unwrap_out       <= '0;
            unwrap_out_valid <= 1'b0;
            unwrap_out_last  <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            unwrap_out_valid <= s2_valid;
            unwrap_out_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                unwrap_out <= sat_val;
            end
            overflow <= (start_acc ? 1'b0 : overflow) | (s2_valid && (sat_hi || sat_lo));
        end
    end

endmodule

// File: tb/tb_phase_unwrap.sv
// Directed self-checking bench for phase_unwrap.
`timescale 1ns / 1ps

module tb_phase_unwrap;

    localparam longint F      = 64'd35184372088832;   // 2^45
    localparam longint PI     = 64'h6487ED5110B4;
    localparam longint TWO_PI = 64'hC90FDAA22168;
    localparam longint MAXV   = 64'h007F_FFFF_FFFF_FFFF;
    localparam longint X30    = 3 * F;
    localparam longint X29    = (29 * F) / 10;
    localparam longint X31    = (31 * F) / 10;
    localparam longint STEP   = (PI * 9) / 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [8:0]   frame_len = '0;
    logic         frame_start = 1'b0;
    logic [47:0]  angle_in = '0;
    logic         angle_in_valid = 1'b0;
    logic [55:0]  unwrap_out;
    logic         unwrap_out_valid;
    logic         unwrap_out_last;
    logic         overflow;
    logic         busy;

    int           n_assert = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           stray_last = 0;
    int           drv_cyc = 0;
    int           base;
    int           t0;
    longint       x;
    longint       q_out[$];
    logic         q_last[$];
    int           q_cyc[$];

    phase_unwrap #(.IN_W(48), .OUT_W(56), .LEN_W(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_len        (frame_len),
        .frame_start      (frame_start),
        .angle_in         (angle_in),
        .angle_in_valid   (angle_in_valid),
        .unwrap_out       (unwrap_out),
        .unwrap_out_valid (unwrap_out_valid),
        .unwrap_out_last  (unwrap_out_last),
        .overflow         (overflow),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector, sampled on the falling edge
    always @(negedge clk) begin
        if (unwrap_out_valid) begin
            q_out.push_back(longint'($signed(unwrap_out)));
            q_last.push_back(unwrap_out_last);
            q_cyc.push_back(cyc);
        end
        if (unwrap_out_last && !unwrap_out_valid) stray_last = stray_last + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_assert = n_assert + 1;
        assert (got === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then drop the strobes
    task automatic send(input logic fs, input int len, input logic v, input longint val);
        frame_start    = fs;
        frame_len      = 9'(len);
        angle_in_valid = v;
        angle_in       = 48'(val);
        drv_cyc        = cyc;
        @(negedge clk);
        frame_start    = 1'b0;
        angle_in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        wait_cycles(3);
        check("rst_out", longint'(unwrap_out), 0);
        check("rst_valid", longint'(unwrap_out_valid), 0);
        check("rst_last", longint'(unwrap_out_last), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        wait_cycles(1);

        // Ramp across the wrap point
        base = q_out.size();
        send(1'b1, 5, 1'b0, 0);
        check("ramp_busy_rise", longint'(busy), 1);
        send(1'b0, 0, 1'b1, X30);
        t0 = drv_cyc;
        send(1'b0, 0, 1'b1, -X30);
        send(1'b0, 0, 1'b1, -X29);
        send(1'b0, 0, 1'b1, X31);
        send(1'b0, 0, 1'b1, -X30);
        check("ramp_busy_fall", longint'(busy), 0);
        wait_cycles(5);
        check("ramp_count", q_out.size() - base, 5);
        check("ramp_o0", q_out[base+0], X30);
        check("ramp_o1", q_out[base+1], TWO_PI - X30);
        check("ramp_o2", q_out[base+2], TWO_PI - X29);
        check("ramp_o3", q_out[base+3], X31);
        check("ramp_o4", q_out[base+4], TWO_PI - X30);
        check("ramp_latency", q_cyc[base+0] - t0, 3);
        check("ramp_last3", longint'(q_last[base+3]), 0);
        check("ramp_last4", longint'(q_last[base+4]), 1);

        // Exact pi step, then pi + 1 LSB, as back-to-back frames
        base = q_out.size();
        send(1'b1, 2, 1'b1, 0);
        send(1'b0, 0, 1'b1, PI);
        send(1'b1, 2, 1'b1, 0);
        send(1'b0, 0, 1'b1, PI + 1);
        wait_cycles(5);
        check("pi_count", q_out.size() - base, 4);
        check("pi_exact", q_out[base+1], PI);
        check("pi_plus1", q_out[base+3], PI + 1 - TWO_PI);
        check("b2b_last1", longint'(q_last[base+1]), 1);
        check("b2b_last3", longint'(q_last[base+3]), 1);
        check("b2b_gapless", q_cyc[base+3] - q_cyc[base+0], 3);

        // Samples in IDLE and zero-length frames are ignored
        base = q_out.size();
        send(1'b0, 0, 1'b1, X30);
        send(1'b0, 0, 1'b1, X29);
        send(1'b1, 0, 1'b0, 0);
        check("len0_busy", longint'(busy), 0);
        send(1'b1, 0, 1'b1, X30);
        check("len0v_busy", longint'(busy), 0);
        wait_cycles(5);
        check("idle_no_out", q_out.size() - base, 0);

        // Single-sample frame
        base = q_out.size();
        send(1'b1, 1, 1'b1, X31);
        check("len1_busy", longint'(busy), 0);
        wait_cycles(4);
        check("len1_count", q_out.size() - base, 1);
        check("len1_val", q_out[base], X31);
        check("len1_last", longint'(q_last[base]), 1);

        // Abort after three samples, restart with a two-sample frame
        base = q_out.size();
        send(1'b1, 8, 1'b0, 0);
        send(1'b0, 0, 1'b1, X30);
        send(1'b0, 0, 1'b1, -X30);
        send(1'b0, 0, 1'b1, -X29);
        send(1'b1, 2, 1'b0, 0);
        send(1'b0, 0, 1'b1, X31);
        send(1'b0, 0, 1'b1, -X30);
        wait_cycles(5);
        check("abort_count", q_out.size() - base, 5);
        check("abort_o2", q_out[base+2], TWO_PI - X29);
        check("abort_o3_raw", q_out[base+3], X31);
        check("abort_o4", q_out[base+4], TWO_PI - X30);
        check("abort_last_old", longint'(q_last[base+2]), 0);
        check("abort_last3", longint'(q_last[base+3]), 0);
        check("abort_last4", longint'(q_last[base+4]), 1);

        // Long frame climbing 0.9*pi per sample until the output saturates
        base = q_out.size();
        send(1'b1, 511, 1'b0, 0);
        x = 0;
        for (int k = 1; k <= 511; k++) begin
            x = x + STEP;
            if (x >= PI) x = x - TWO_PI;
            send(1'b0, 0, 1'b1, x);
            if (k == 300) check("ovf_low_early", longint'(overflow), 0);
        end
        wait_cycles(5);
        check("ovf_count", q_out.size() - base, 511);
        check("ovf_o300", q_out[base+299], 300 * STEP);
        check("ovf_o400_sat", q_out[base+399], MAXV);
        check("ovf_o511_sat", q_out[base+510], MAXV);
        check("ovf_last", longint'(q_last[base+510]), 1);
        check("ovf_sticky", longint'(overflow), 1);
        send(1'b1, 3, 1'b0, 0);
        check("ovf_cleared", longint'(overflow), 0);

        // Reset with two samples in flight
        send(1'b1, 4, 1'b0, 0);
        send(1'b0, 0, 1'b1, X30);
        send(1'b0, 0, 1'b1, -X29);
        base = q_out.size();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(5);
        check("rstmid_no_out", q_out.size() - base, 0);
        check("rstmid_out", longint'(unwrap_out), 0);
        check("rstmid_busy", longint'(busy), 0);
        send(1'b1, 1, 1'b1, -X30);
        wait_cycles(4);
        check("fresh_count", q_out.size() - base, 1);
        check("fresh_val", q_out[base], -X30);
        check("fresh_last", longint'(q_last[base]), 1);
        check("stray_last", stray_last, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
